// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the game timing-base generator.
// Defaults target a 100 MHz board clock.
package tick_gen_pkg;

    localparam int DEF_CLK_HZ       = 100_000_000;
    localparam int DEF_SMALL_DIV    = 50_000;
    localparam int DEF_SCREEN_DIV   = 500_000_000;
    localparam int DEF_NUM_LEV      = 3;
    localparam int DEF_LEV_BASE_DIV = 300_000_000;
    localparam int DEF_LEV_STEP_DIV = 100_000_000;
    localparam int DEF_CNT_W        = 30;

    // Width of the level index; never narrower than one bit.
    function automatic int lev_w(input int num_lev);
        return (num_lev > 1) ? $clog2(num_lev) : 1;
    endfunction

    // Half-period of the level channel at level k.
    // The caller narrows the result to its counter width.
    function automatic logic [31:0] lev_div(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned k);
        return base - k * step;
    endfunction

endpackage

// File: rtl/tick_gen_div.sv
// One divider channel. It either toggles a square wave or emits a one-cycle strobe.
// DIV=0 selects the runtime divisor on div_in.
module tick_div #(
    parameter int DIV    = 2,
    parameter int CNT_W  = 8,
    parameter bit TOGGLE = 1'b1
) (
    input  logic             clk_orig,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div_in,
    output logic             out,
    output logic             strobe
);

    localparam logic [CNT_W-1:0] DIV_FIX = CNT_W'(DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_eff;
    logic             term;

    assign div_eff = (DIV > 0) ? DIV_FIX : div_in;
    assign term    = (cnt == div_eff - 1'b1);

    // clr outranks the terminal count: the counter restarts and out holds, so no short half-period is produced.
    always_ff @(posedge clk_orig) begin
        if (rst) begin
            cnt    <= '0;
            out    <= 1'b0;
            strobe <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (en) begin
            if (term) begin
                cnt <= '0;
                if (TOGGLE) begin
                    out    <= ~out;
                    strobe <= ~out;
                end else begin
                    strobe <= 1'b1;
                end
            end else begin
                cnt    <= cnt + 1'b1;
                strobe <= 1'b0;
            end
        end else begin
            strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_gen_bank.sv
// Timing-base generator: 1 Hz strobe, scan and screen square waves, and a level-dependent mole rate.
// The level button is synchronised into clk_orig and edge-detected.
module tick_gen_bank
    import tick_gen_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int SMALL_DIV    = DEF_SMALL_DIV,
    parameter int SCREEN_DIV   = DEF_SCREEN_DIV,
    parameter int NUM_LEV      = DEF_NUM_LEV,
    parameter int LEV_BASE_DIV = DEF_LEV_BASE_DIV,
    parameter int LEV_STEP_DIV = DEF_LEV_STEP_DIV,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                        clk_orig,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        lev,
    output logic [lev_w(NUM_LEV)-1:0]   lev_sel,
    output logic                        clk_1hz,
    output logic                        clk_small,
    output logic                        clk_screen,
    output logic                        clk_lev,
    output logic                        lev_tick
);

    localparam int               LEV_W   = lev_w(NUM_LEV);
    localparam logic [LEV_W-1:0] LEV_MAX = LEV_W'(NUM_LEV - 1);

    logic             lev_s1;
    logic             lev_s2;
    logic             lev_s3;
    logic             lev_edge;
    logic [CNT_W-1:0] lev_div_cur;
    logic             hz_out_nc;
    logic             small_stb_nc;
    logic             screen_stb_nc;
    logic             unused_sig;

    // Level changes are taken even while paused, so the player can pick a level before starting.
    always_ff @(posedge clk_orig) begin
        if (rst) begin
            lev_s1  <= 1'b0;
            lev_s2  <= 1'b0;
            lev_s3  <= 1'b0;
            lev_sel <= '0;
        end else begin
            lev_s1 <= lev;
            lev_s2 <= lev_s1;
            lev_s3 <= lev_s2;
            if (lev_edge) begin
                lev_sel <= (lev_sel == LEV_MAX) ? '0 : lev_sel + 1'b1;
            end
        end
    end

    assign lev_edge    = lev_s2 & ~lev_s3;
    assign lev_div_cur = CNT_W'(lev_div(LEV_BASE_DIV, LEV_STEP_DIV, 32'(lev_sel)));

    tick_div #(.DIV(CLK_HZ), .CNT_W(CNT_W), .TOGGLE(1'b0)) u_div_1hz (
        .clk_orig (clk_orig),
        .rst      (rst),
        .en       (run),
        .clr      (1'b0),
        .div_in   ('0),
        .out      (hz_out_nc),
        .strobe   (clk_1hz)
    );

    tick_div #(.DIV(SMALL_DIV), .CNT_W(CNT_W), .TOGGLE(1'b1)) u_div_small (
        .clk_orig (clk_orig),
        .rst      (rst),
        .en       (run),
        .clr      (1'b0),
        .div_in   ('0),
        .out      (clk_small),
        .strobe   (small_stb_nc)
    );

    tick_div #(.DIV(SCREEN_DIV), .CNT_W(CNT_W), .TOGGLE(1'b1)) u_div_screen (
        .clk_orig (clk_orig),
        .rst      (rst),
        .en       (run),
        .clr      (1'b0),
        .div_in   ('0),
        .out      (clk_screen),
        .strobe   (screen_stb_nc)
    );

    // The level channel restarts from zero whenever the level changes.
    tick_div #(.DIV(0), .CNT_W(CNT_W), .TOGGLE(1'b1)) u_div_lev (
        .clk_orig (clk_orig),
        .rst      (rst),
        .en       (run),
        .clr      (lev_edge),
        .div_in   (lev_div_cur),
        .out      (clk_lev),
        .strobe   (lev_tick)
    );

    assign unused_sig = &{1'b0, hz_out_nc, small_stb_nc, screen_stb_nc};

endmodule

// File: tb/tb_tick_gen_bank.sv
// Bench for tick_gen_bank at simulation sizing.
// A countdown reference model feeds a scoreboard, backed by hand-derived corner-case checks and a vector table.
module tb_tick_gen_bank;

    localparam int CLK_HZ       = 10;
    localparam int SMALL_DIV    = 2;
    localparam int SCREEN_DIV   = 5;
    localparam int NUM_LEV      = 3;
    localparam int LEV_BASE_DIV = 6;
    localparam int LEV_STEP_DIV = 2;
    localparam int CNT_W        = 8;

    logic       clk_orig = 1'b0;
    logic       rst      = 1'b1;
    logic       run      = 1'b0;
    logic       lev      = 1'b0;
    logic [1:0] lev_sel;
    logic       clk_1hz;
    logic       clk_small;
    logic       clk_screen;
    logic       clk_lev;
    logic       lev_tick;

    always #5 clk_orig = ~clk_orig;

    tick_gen_bank #(
        .CLK_HZ       (CLK_HZ),
        .SMALL_DIV    (SMALL_DIV),
        .SCREEN_DIV   (SCREEN_DIV),
        .NUM_LEV      (NUM_LEV),
        .LEV_BASE_DIV (LEV_BASE_DIV),
        .LEV_STEP_DIV (LEV_STEP_DIV),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_orig   (clk_orig),
        .rst        (rst),
        .run        (run),
        .lev        (lev),
        .lev_sel    (lev_sel),
        .clk_1hz    (clk_1hz),
        .clk_small  (clk_small),
        .clk_screen (clk_screen),
        .clk_lev    (clk_lev),
        .lev_tick   (lev_tick)
    );

    typedef struct packed {
        logic [1:0] f_sel;
        logic       f_hz;
        logic       f_sml;
        logic       f_scr;
        logic       f_lev;
        logic       f_tick;
    } out_t;

    typedef struct {
        bit r;
        bit ru;
        bit lv;
        int cycles;
        int exp_sel;
    } vec_t;

    out_t exp_q[$];
    out_t m;
    bit   m_s1, m_s2, m_s3;
    int   rem_hz, rem_sml, rem_scr, rem_lev;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic int div_of(input int k);
        return LEV_BASE_DIV - k * LEV_STEP_DIV;
    endfunction

    // Reference model: each channel counts down the cycles remaining until its next event.
    task automatic modelStep(input bit r, input bit ru, input bit lv);
        bit lv_edge;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
            m = '0;
            rem_hz = CLK_HZ; rem_sml = SMALL_DIV; rem_scr = SCREEN_DIV; rem_lev = div_of(0);
        end else begin
            lv_edge = m_s2 && !m_s3;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = lv;
            m.f_hz = 1'b0;
            m.f_tick = 1'b0;
            if (lv_edge) begin
                m.f_sel = (m.f_sel == 2'(NUM_LEV - 1)) ? 2'd0 : m.f_sel + 2'd1;
                rem_lev = div_of(int'(m.f_sel));
            end
            if (ru) begin
                rem_hz--;
                if (rem_hz == 0) begin rem_hz = CLK_HZ; m.f_hz = 1'b1; end
                rem_sml--;
                if (rem_sml == 0) begin rem_sml = SMALL_DIV; m.f_sml = ~m.f_sml; end
                rem_scr--;
                if (rem_scr == 0) begin rem_scr = SCREEN_DIV; m.f_scr = ~m.f_scr; end
                if (!lv_edge) begin
                    rem_lev--;
                    if (rem_lev == 0) begin
                        rem_lev = div_of(int'(m.f_sel));
                        m.f_lev = ~m.f_lev;
                        m.f_tick = m.f_lev;
                    end
                end
            end
        end
        exp_q.push_back(m);
    endtask

    task automatic checkOutput();
        out_t e;
        out_t a;
        a = {lev_sel, clk_1hz, clk_small, clk_screen, clk_lev, lev_tick};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty cycle=%0d", cyc);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("[TB] FAIL cycle_%0d got sel=%0d hz=%b sml=%b scr=%b lev=%b tick=%b want sel=%0d hz=%b sml=%b scr=%b lev=%b tick=%b",
                         cyc, a.f_sel, a.f_hz, a.f_sml, a.f_scr, a.f_lev, a.f_tick,
                         e.f_sel, e.f_hz, e.f_sml, e.f_scr, e.f_lev, e.f_tick);
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ru, input bit lv);
        rst = r; run = ru; lev = lv;
        modelStep(r, ru, lv);
        @(posedge clk_orig);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic pulseLev();
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic runUntilLevChange(input int budget, output int n);
        logic v;
        v = clk_lev;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (clk_lev !== v) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic runUntilHz(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (clk_1hz === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   hz_hits[$];
        int   tick_hits[$];
        int   n;

        vecs[0] = '{1'b1, 1'b0, 1'b0,  2, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b1,  3, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b0,  5, 1};
        vecs[3] = '{1'b0, 1'b0, 1'b1,  4, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b0,  3, 2};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 10, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 20, 0};
        vecs[7] = '{1'b1, 1'b1, 1'b1,  1, 0};
        vecs[8] = '{1'b0, 1'b1, 1'b0,  8, 0};

        $display("[TB] free-running channels from reset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkInt("reset_outputs", int'({lev_sel, clk_1hz, clk_small, clk_screen, clk_lev, lev_tick}), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (clk_1hz === 1'b1) hz_hits.push_back(i);
            if (lev_tick === 1'b1) tick_hits.push_back(i);
        end
        checkInt("hz_count", hz_hits.size(), 3);
        if (hz_hits.size() == 3) begin
            checkInt("hz_first", hz_hits[0], 10);
            checkInt("hz_third", hz_hits[2], 30);
        end
        checkInt("tick_count", tick_hits.size(), 3);
        if (tick_hits.size() == 3) begin
            checkInt("tick_first", tick_hits[0], 6);
            checkInt("tick_second", tick_hits[1], 18);
        end
        checkInt("small_after30", int'(clk_small), 1);
        checkInt("screen_after30", int'(clk_screen), 0);
        checkInt("lev_after30", int'(clk_lev), 1);

        $display("[TB] single level pulse and held button");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkInt("sel_pulse_c1", int'(lev_sel), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("sel_pulse_c2", int'(lev_sel), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("sel_pulse_c3", int'(lev_sel), 1);
        checkInt("lev_hold_on_change", int'(clk_lev), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("lev_still_high", int'(clk_lev), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("lev_toggle_after4", int'(clk_lev), 0);
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkInt("sel_held_high", int'(lev_sel), 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("sel_after_release", int'(lev_sel), 2);

        $display("[TB] level sweep half-periods");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulseLev();
        checkInt("sweep_sel1", int'(lev_sel), 1);
        runUntilLevChange(30, n);
        checkInt("half_period_lev1", n, 4);
        pulseLev();
        checkInt("sweep_sel2", int'(lev_sel), 2);
        runUntilLevChange(30, n);
        checkInt("half_period_lev2", n, 2);
        pulseLev();
        checkInt("sweep_sel0", int'(lev_sel), 0);
        runUntilLevChange(30, n);
        checkInt("half_period_lev0", n, 6);

        $display("[TB] pause mid-period");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b0, i == 1);
            checkInt($sformatf("pause_hz_%0d", i), int'(clk_1hz), 0);
        end
        checkInt("pause_small_frozen", int'(clk_small), 0);
        checkInt("pause_sel_updates", int'(lev_sel), 1);
        runUntilHz(20, n);
        checkInt("hz_after_resume", n, 6);

        $display("[TB] level change on lev terminal count");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("coll_sel_before", int'(lev_sel), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("coll_sel", int'(lev_sel), 1);
        checkInt("coll_no_toggle", int'(clk_lev), 0);
        checkInt("coll_no_tick", int'(lev_tick), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("coll_hold", int'(clk_lev), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkInt("coll_rise", int'({clk_lev, lev_tick}), 3);

        $display("[TB] reset mid-run");
        pulseLev();
        checkInt("mid_sel2", int'(lev_sel), 2);
        for (int i = 0; i < 10; i++) begin
            if (clk_lev === 1'b1) break;
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkInt("mid_lev_high", int'(clk_lev), 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkInt("mid_rst_zero", int'({lev_sel, clk_1hz, clk_small, clk_screen, clk_lev, lev_tick}), 0);
        runUntilLevChange(20, n);
        checkInt("first_rise_after_rst", n, 6);
        checkInt("first_rise_tick", int'(lev_tick), 1);

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(vecs[i].r, vecs[i].ru, vecs[i].lv);
            end
            checkInt($sformatf("vec%0d_sel", i), int'(lev_sel), vecs[i].exp_sel);
        end

        checkInt("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_gen_bank.md
Name: tick_gen_bank

Overview:
- Parametrised timing-base generator for the game; a successor to the fixed-rate clock divider.
- Produces from the single board clock:
  - a 1 Hz single-cycle strobe;
  - scan and screen square waves;
  - a level-dependent mole-rate square wave plus its strobe.
- Level button is synchronised and edge-detected inside the clock domain; no logic is clocked by the button.
- Global run/pause freezes all timebases together.

Parameters:
- CLK_HZ, 100000000, input clock frequency; sets the 1 Hz strobe period.
- SMALL_DIV, 50000, clk_orig cycles per clk_small half-period.
- SCREEN_DIV, 500000000, clk_orig cycles per clk_screen half-period.
- NUM_LEV, 3, number of difficulty levels (2..8).
- LEV_BASE_DIV, 300000000, clk_lev half-period at level 0, in clk_orig cycles.
- LEV_STEP_DIV, 100000000, half-period reduction per level; LEV_BASE_DIV - (NUM_LEV-1)*LEV_STEP_DIV must be >= 2.
- CNT_W, 30, counter width; must hold max(CLK_HZ, SCREEN_DIV, LEV_BASE_DIV).

Ports:
- clk_orig, in, 1, board clock.
- rst, in, 1, synchronous active-high reset.
- run, in, 1, 1 = counters advance; 0 = all counters and outputs hold.
- lev, in, 1, raw level-advance button, asynchronous to clk_orig.
- lev_sel, out, $clog2(NUM_LEV), current level index.
- clk_1hz, out, 1, one-cycle strobe every CLK_HZ cycles.
- clk_small, out, 1, square wave with period 2*SMALL_DIV cycles.
- clk_screen, out, 1, square wave with period 2*SCREEN_DIV cycles.
- clk_lev, out, 1, square wave with half-period div(lev_sel).
- lev_tick, out, 1, one-cycle strobe coincident with each clk_lev rising transition.

Behaviour:
- Reset (synchronous, rst=1 at a clk_orig edge):
  - all counters = 0;
  - clk_1hz = clk_small = clk_screen = clk_lev = lev_tick = 0;
  - lev_sel = 0;
  - synchroniser and edge-detect flops = 0.
  - rst has priority over run and lev.
- Level divisor: div(k) = LEV_BASE_DIV - k*LEV_STEP_DIV, computed at CNT_W bits. Defaults give 300M, 200M, 100M.
- Generic divider rule, applied to each channel with its divisor D, only while run=1:
  - if cnt == D-1: cnt <= 0, action;
  - else: cnt <= cnt+1.
- Channel actions on terminal count:
  - clk_1hz is registered and high exactly the cycle after cnt reached CLK_HZ-1, low otherwise.
  - clk_small, clk_screen and clk_lev invert on their terminal counts.
  - lev_tick = 1 for one cycle when clk_lev goes 0 to 1 (same registered edge).
- run=0:
  - counters hold, square outputs hold;
  - clk_1hz and lev_tick are forced 0;
  - lev edges are still captured and lev_sel still updates.
- Level input path:
  - 2-flop synchroniser, then a third flop for rising-edge detect; lev_edge is asserted 3 cycles after lev rises.
  - On lev_edge: lev_sel <= (lev_sel == NUM_LEV-1) ? 0 : lev_sel+1.
  - Held-high lev produces exactly one edge. Debounce is handled upstream.
- Level change: in the same cycle as the lev_sel update, the lev counter is cleared to 0 and clk_lev holds its value. The next clk_lev toggle occurs a full div(new) cycles later. No short or runt half-period.
- Level change coinciding with lev terminal count: level change wins. Counter goes to 0 with no toggle and no lev_tick.
- Other channels are unaffected by level changes.
- Counter compare uses equality only; the wrap point is D-1, so no counter ever exceeds D-1.
- No latency outside the stated registered outputs.

Decomposition:
- Package tick_gen_pkg holds:
  - function lev_div(k) returning CNT_W-bit divisors;
  - LEV_W = $clog2(NUM_LEV) helper;
  - the default divisor constants.
- Sub-module tick_div (params DIV, CNT_W, TOGGLE):
  - ports: clk_orig, rst, en, clr, div_in (runtime divisor, used by the lev channel), out, strobe.
  - Instantiated four times.
- Synchroniser and edge detect stay inline in tick_gen_bank.

Test Plan:
1. Simulation sizing (CLK_HZ=10, SMALL_DIV=2, SCREEN_DIV=5, LEV_BASE_DIV=6, LEV_STEP_DIV=2, CNT_W=8), rst 2 cycles then run=1 → clk_1hz high on cycles 10, 20, 30; clk_small toggles every 2 cycles; clk_screen every 5; clk_lev every 6, with lev_tick on every second toggle (period 12).
2. Pulse lev for 1 cycle → lev_sel 0→1 exactly 3 cycles later; next clk_lev toggle 4 cycles after the update; hold lev high 50 cycles → only one increment.
3. Three lev pulses from reset → lev_sel 1, 2, 0; clk_lev half-periods 4, 2, 6.
4. run=0 for 7 cycles mid-period at cnt_1hz=4 → no strobes, outputs frozen; after run=1, clk_1hz asserts 6 cycles later.
5. lev_edge on the same cycle as lev terminal count → no clk_lev toggle and no lev_tick; counter 0.
6. rst asserted mid-run with lev_sel=2, clk_lev=1 → next cycle all outputs 0, lev_sel=0; first clk_lev rise 6 cycles after rst release.
